// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock buzzer path: sequencer state codes,
// buzzer owner codes and the BCD hour conversion helper.
package clock_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CH_ON  = 3'd1;
  localparam state_t ST_CH_OFF = 3'd2;
  localparam state_t ST_AL_ON  = 3'd3;
  localparam state_t ST_AL_OFF = 3'd4;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_CHIME = 2'd1,
    SRC_ALARM = 2'd2,
    SRC_HALF  = 2'd3
  } src_e;

  typedef struct packed {
    logic       vld;
    logic [4:0] val;
  } bcd_bin_t;

  // Only tens digits 0/1 are legal for a 12-hour clock, so bit 4 alone selects the +10.
  function automatic bcd_bin_t bcd8_to_bin(input logic [7:0] bcd);
    bcd_bin_t r;
    r.vld = (bcd[3:0] <= 4'd9) && (bcd[7:4] <= 4'd1);
    r.val = (bcd[4] ? 5'd10 : 5'd0) + {1'b0, bcd[3:0]};
    return r;
  endfunction

endpackage

// File: rtl/chime_sequencer_if.sv
// Signal bundle between the time counters / keys and the buzzer sequencer.
interface chime_sequencer_if;

  logic       sec_pulse;
  logic [7:0] Hour12;
  logic [7:0] Minute;
  logic [7:0] Second;
  logic       tell_en;
  logic       alarm_hit;
  logic       alarm_stop;
  logic       tone;
  logic       Di;
  logic       busy;
  logic [1:0] src;

  modport master (
    output sec_pulse, Hour12, Minute, Second, tell_en, alarm_hit, alarm_stop, tone,
    input  Di, busy, src
  );

  modport slave (
    input  sec_pulse, Hour12, Minute, Second, tell_en, alarm_hit, alarm_stop, tone,
    output Di, busy, src
  );

endinterface

// File: rtl/beep_timer.sv
// Beep phase timer: a start pulse loads the selected phase length, and done strobes
// during the last cycle of that phase so the FSM can change state on the next edge.
module beep_timer #(
  parameter int BEEP_ON_CYC  = 500,
  parameter int BEEP_OFF_CYC = 500,
  parameter int CNT_W        = 16
) (
  input  logic CP,
  input  logic CR,
  input  logic start_i,
  input  logic phase_on_i,
  output logic done_o
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(BEEP_ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(BEEP_OFF_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start_i) begin
      cnt_d    = phase_on_i ? ON_LAST : OFF_LAST;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/chime_sequencer.sv
// Buzzer owner for the digital clock: hourly chime of N beeps and a capped, stoppable alarm.
// Defining CHIME_HALF_EN adds a single half-hour beep reported as the half-hour owner.
module chime_sequencer
  import clock_pkg::*;
#(
  parameter int BEEP_ON_CYC     = 500,
  parameter int BEEP_OFF_CYC    = 500,
  parameter int ALARM_MAX_BEEPS = 60,
  parameter int CNT_W           = 16
) (
  input logic              CP,
  input logic              CR,
  chime_sequencer_if.slave bus
);

  state_t     state_q, state_d;
  logic [3:0] beeps_left_q, beeps_left_d;
  logic [7:0] al_cnt_q, al_cnt_d;
  logic       hit_q;
  logic       beep_on_q, beep_on_d;
  logic       busy_q, busy_d;
  src_e       src_q, src_d;

  bcd_bin_t   hour;
  logic       hour_ok;
  logic       top_of_min;
  logic       chime_trig;
  logic       half_trig;
  logic       alarm_edge;
  logic       in_alarm;
  logic       tmr_start;
  logic       tmr_phase_on;
  logic       tmr_done;

  assign hour       = bcd8_to_bin(bus.Hour12);
  assign hour_ok    = hour.vld && (hour.val >= 5'd1) && (hour.val <= 5'd12);
  assign top_of_min = bus.sec_pulse && bus.tell_en && (bus.Second == 8'h00);
  assign chime_trig = top_of_min && (bus.Minute == 8'h00) && hour_ok;
`ifdef CHIME_HALF_EN
  assign half_trig  = top_of_min && (bus.Minute == 8'h30);
`else
  assign half_trig  = 1'b0;
`endif
  assign alarm_edge = bus.alarm_hit && !hit_q;
  assign in_alarm   = (state_q == ST_AL_ON) || (state_q == ST_AL_OFF);

  always_comb begin
    state_d      = state_q;
    beeps_left_d = beeps_left_q;
    al_cnt_d     = al_cnt_q;
    src_d        = src_q;

    // The alarm pre-empts idle and any chime; a pre-empted chime is simply dropped.
    if (alarm_edge && !in_alarm) begin
      state_d  = ST_AL_ON;
      al_cnt_d = 8'd0;
      src_d    = SRC_ALARM;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (chime_trig) begin
            state_d      = ST_CH_ON;
            beeps_left_d = hour.val[3:0];
            src_d        = SRC_CHIME;
          end else if (half_trig) begin
            state_d      = ST_CH_ON;
            beeps_left_d = 4'd1;
            src_d        = SRC_HALF;
          end
        end
        ST_CH_ON: begin
          if (!bus.tell_en) begin
            state_d = ST_IDLE;
          end else if (tmr_done) begin
            state_d      = ST_CH_OFF;
            beeps_left_d = beeps_left_q - 4'd1;
          end
        end
        ST_CH_OFF: begin
          if (!bus.tell_en) begin
            state_d = ST_IDLE;
          end else if (tmr_done) begin
            state_d = (beeps_left_q != 4'd0) ? ST_CH_ON : ST_IDLE;
          end
        end
        ST_AL_ON: begin
          if (bus.alarm_stop) begin
            state_d = ST_IDLE;
          end else if (tmr_done) begin
            if (al_cnt_q == 8'(ALARM_MAX_BEEPS - 1)) begin
              state_d = ST_IDLE;
            end else begin
              state_d  = ST_AL_OFF;
              al_cnt_d = al_cnt_q + 8'd1;
            end
          end
        end
        ST_AL_OFF: begin
          if (bus.alarm_stop) begin
            state_d = ST_IDLE;
          end else if (tmr_done) begin
            state_d = ST_AL_ON;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d == ST_IDLE) begin
      src_d = SRC_NONE;
    end
  end

  // Every state change into a beep state opens a fresh phase.
  assign tmr_start    = (state_d != state_q) && (state_d != ST_IDLE);
  assign tmr_phase_on = (state_d == ST_CH_ON) || (state_d == ST_AL_ON);
  assign beep_on_d    = tmr_phase_on;
  assign busy_d       = (state_d != ST_IDLE);

  beep_timer #(
    .BEEP_ON_CYC  (BEEP_ON_CYC),
    .BEEP_OFF_CYC (BEEP_OFF_CYC),
    .CNT_W        (CNT_W)
  ) u_timer (
    .CP         (CP),
    .CR         (CR),
    .start_i    (tmr_start),
    .phase_on_i (tmr_phase_on),
    .done_o     (tmr_done)
  );

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_q      <= ST_IDLE;
      beeps_left_q <= 4'd0;
      al_cnt_q     <= 8'd0;
      hit_q        <= 1'b0;
      beep_on_q    <= 1'b0;
      busy_q       <= 1'b0;
      src_q        <= SRC_NONE;
    end else begin
      state_q      <= state_d;
      beeps_left_q <= beeps_left_d;
      al_cnt_q     <= al_cnt_d;
      hit_q        <= bus.alarm_hit;
      beep_on_q    <= beep_on_d;
      busy_q       <= busy_d;
      src_q        <= src_d;
    end
  end

  assign bus.Di   = beep_on_q & bus.tone;
  assign bus.busy = busy_q;
  assign bus.src  = src_q;

endmodule

// File: tb/tb_chime_sequencer.sv
// Bench for chime_sequencer: vector table of chime triggers, hand-written alarm/reset
// sequences, then random traffic, all cross-checked each cycle against a timeline model.
module tb_chime_sequencer;

  localparam int ON   = 4;
  localparam int OFF  = 4;
  localparam int MAXB = 5;
  localparam int P    = ON + OFF;

  logic CP = 1'b0;
  logic CR;

  chime_sequencer_if bus ();

  chime_sequencer #(
    .BEEP_ON_CYC     (ON),
    .BEEP_OFF_CYC    (OFF),
    .ALARM_MAX_BEEPS (MAXB),
    .CNT_W           (16)
  ) dut (
    .CP  (CP),
    .CR  (CR),
    .bus (bus)
  );

  always #5 CP = ~CP;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the buzzer and how many cycles into its sequence we are.
  int m_src;
  int m_t;
  int m_n;
  bit m_prev;

  typedef struct {
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic       tell;
    int         busy_cyc;
    int         beeps;
    int         src;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_src  = 0;
    m_t    = 0;
    m_n    = 0;
    m_prev = 1'b0;
  endtask

  task automatic model_step();
    bit rise;
    int h, tens, units, val;
    rise   = bus.alarm_hit && !m_prev;
    m_prev = bus.alarm_hit;
    h      = int'(bus.Hour12);
    tens   = h / 16;
    units  = h % 16;
    val    = tens * 10 + units;
    if (m_src != 2 && rise) begin
      m_src = 2;
      m_t   = 0;
    end else if (m_src == 2) begin
      if (bus.alarm_stop) m_src = 0;
      else begin
        m_t++;
        if (m_t == (MAXB - 1) * P + ON) m_src = 0;
      end
    end else if (m_src != 0) begin
      if (!bus.tell_en) m_src = 0;
      else begin
        m_t++;
        if (m_t == m_n * P) m_src = 0;
      end
    end else if (bus.sec_pulse && bus.tell_en && bus.Second == 8'h00) begin
      if (bus.Minute == 8'h00 && units <= 9 && tens <= 1 && val >= 1 && val <= 12) begin
        m_src = 1;
        m_n   = val;
        m_t   = 0;
      end
`ifdef CHIME_HALF_EN
      else if (bus.Minute == 8'h30) begin
        m_src = 3;
        m_n   = 1;
        m_t   = 0;
      end
`endif
    end
  endtask

  task automatic tick();
    int exp_on;
    @(posedge CP);
    model_step();
    #1;
    exp_on = (m_src != 0 && (m_t % P) < ON) ? 1 : 0;
    chk("cyc_di", int'(bus.Di), exp_on & int'(bus.tone));
    chk("cyc_busy", int'(bus.busy), (m_src != 0) ? 1 : 0);
    chk("cyc_src", int'(bus.src), m_src);
  endtask

  task automatic idle_inputs();
    bus.sec_pulse  = 1'b0;
    bus.Hour12     = 8'h01;
    bus.Minute     = 8'h15;
    bus.Second     = 8'h17;
    bus.tell_en    = 1'b1;
    bus.alarm_hit  = 1'b0;
    bus.alarm_stop = 1'b0;
    bus.tone       = 1'b1;
  endtask

  // Runs a bounded window, measuring busy cycles, Di windows and their lengths.
  task automatic run_seq(input int ncyc, output int busy_cnt, output int wins,
                         output int src_seen, output int bad_len, output int first_src);
    bit prev;
    int len;
    prev = 1'b0; len = 0;
    busy_cnt = 0; wins = 0; src_seen = 0; bad_len = 0; first_src = 0;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      if (c == 0) begin
        bus.sec_pulse = 1'b0;
        first_src     = int'(bus.src);
      end
      if (bus.busy) begin
        busy_cnt++;
        src_seen = int'(bus.src);
      end
      if (bus.Di) begin
        if (!prev) wins++;
        len++;
      end else begin
        if (prev && len != ON) bad_len++;
        len = 0;
      end
      prev = bus.Di;
    end
  endtask

  task automatic rand_drive();
    int v;
    bus.sec_pulse = ($urandom_range(5) == 0);
    if ($urandom_range(3) == 0) bus.Hour12 = 8'($urandom_range(255));
    else begin
      v = $urandom_range(12, 1);
      bus.Hour12 = 8'((v / 10) * 16 + (v % 10));
    end
    case ($urandom_range(2))
      0:       bus.Minute = 8'h00;
      1:       bus.Minute = 8'h30;
      default: bus.Minute = 8'($urandom_range(255));
    endcase
    bus.Second     = ($urandom_range(3) != 0) ? 8'h00 : 8'($urandom_range(255));
    bus.tell_en    = ($urandom_range(149) != 0);
    if ($urandom_range(79) == 0) bus.alarm_hit = ~bus.alarm_hit;
    bus.alarm_stop = ($urandom_range(49) == 0);
    bus.tone       = 1'($urandom_range(1));
  endtask

  initial begin
    int bc, wn, ss, bl, fs;

    vecs[0]  = '{8'h03, 8'h00, 8'h00, 1'b1, 24, 3, 1};
    vecs[1]  = '{8'h12, 8'h00, 8'h00, 1'b1, 96, 12, 1};
    vecs[2]  = '{8'h00, 8'h00, 8'h00, 1'b1, 0, 0, 0};
    vecs[3]  = '{8'h13, 8'h00, 8'h00, 1'b1, 0, 0, 0};
    vecs[4]  = '{8'h1A, 8'h00, 8'h00, 1'b1, 0, 0, 0};
    vecs[5]  = '{8'h01, 8'h00, 8'h00, 1'b1, 8, 1, 1};
    vecs[6]  = '{8'h10, 8'h00, 8'h00, 1'b1, 80, 10, 1};
    vecs[7]  = '{8'h0A, 8'h00, 8'h00, 1'b1, 0, 0, 0};
    vecs[8]  = '{8'h03, 8'h00, 8'h00, 1'b0, 0, 0, 0};
    vecs[9]  = '{8'h05, 8'h01, 8'h00, 1'b1, 0, 0, 0};
    vecs[10] = '{8'h05, 8'h00, 8'h01, 1'b1, 0, 0, 0};
`ifdef CHIME_HALF_EN
    vecs[11] = '{8'h07, 8'h30, 8'h00, 1'b1, 8, 1, 3};
`else
    vecs[11] = '{8'h07, 8'h30, 8'h00, 1'b1, 0, 0, 0};
`endif

    idle_inputs();
    CR = 1'b1;
    model_reset();
    @(posedge CP);
    @(posedge CP);
    #1;
    chk("reset_di", int'(bus.Di), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_src", int'(bus.src), 0);
    CR = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      bus.Hour12    = vecs[i].hour;
      bus.Minute    = vecs[i].minute;
      bus.Second    = vecs[i].second;
      bus.tell_en   = vecs[i].tell;
      bus.sec_pulse = 1'b1;
      run_seq(120, bc, wn, ss, bl, fs);
      chk($sformatf("vec%0d_busy", i), bc, vecs[i].busy_cyc);
      chk($sformatf("vec%0d_beeps", i), wn, vecs[i].beeps);
      chk($sformatf("vec%0d_src", i), ss, vecs[i].src);
      chk($sformatf("vec%0d_beeplen", i), bl, 0);
      bus.tell_en = 1'b1;
    end

    // Chime at 9 o'clock pre-empted by the alarm in its second beep.
    bus.Hour12 = 8'h09; bus.Minute = 8'h00; bus.Second = 8'h00; bus.sec_pulse = 1'b1;
    tick();
    bus.sec_pulse = 1'b0;
    for (int c = 0; c < P + 1; c++) tick();
    chk("preempt_in_beep2", int'(bus.Di), 1);
    bus.alarm_hit = 1'b1;
    run_seq(60, bc, wn, ss, bl, fs);
    chk("preempt_first_src", fs, 2);
    chk("preempt_busy", bc, (MAXB - 1) * P + ON);
    chk("preempt_beeps", wn, MAXB);
    chk("preempt_beeplen", bl, 0);

    // Alarm runs to its cap from idle.
    bus.alarm_hit = 1'b0;
    tick(); tick();
    bus.alarm_hit = 1'b1;
    run_seq(60, bc, wn, ss, bl, fs);
    chk("alarm_cap_busy", bc, (MAXB - 1) * P + ON);
    chk("alarm_cap_beeps", wn, MAXB);
    chk("alarm_cap_src", ss, 2);

    // Alarm stopped in the off-phase of its second beep.
    bus.alarm_hit = 1'b0;
    tick(); tick();
    bus.alarm_hit = 1'b1;
    tick();
    for (int c = 0; c < P + ON + 1; c++) tick();
    chk("stop_pre_busy", int'(bus.busy), 1);
    chk("stop_pre_di", int'(bus.Di), 0);
    bus.alarm_stop = 1'b1;
    tick();
    bus.alarm_stop = 1'b0;
    chk("stop_busy", int'(bus.busy), 0);
    chk("stop_src", int'(bus.src), 0);
    bus.alarm_hit = 1'b0;
    tick();

    // Asynchronous reset in the middle of an on-phase.
    bus.Hour12 = 8'h03; bus.Minute = 8'h00; bus.Second = 8'h00; bus.sec_pulse = 1'b1;
    tick();
    bus.sec_pulse = 1'b0;
    tick(); tick();
    chk("arst_pre_di", int'(bus.Di), 1);
    #2;
    CR = 1'b1;
    #1;
    chk("arst_di", int'(bus.Di), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_src", int'(bus.src), 0);
    model_reset();
    #1;
    CR = 1'b0;
    bus.Hour12 = 8'h01; bus.sec_pulse = 1'b1;
    run_seq(20, bc, wn, ss, bl, fs);
    chk("after_arst_busy", bc, P);
    chk("after_arst_beeps", wn, 1);

    for (int c = 0; c < 4000; c++) begin
      rand_drive();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
